// File: rtl/inst_align_buffer_pkg.sv
// Shared fetch-side types and constants for the instruction align buffer.
// Optional compressed-instruction support is selected with INST_ALIGN_COMPRESSED_EN.
package inst_align_buffer_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Low two bits of the first halfword that mark a full 32-bit instruction
  localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

endpackage

// File: rtl/inst_align_buffer_halfword_fifo.sv
// Halfword FIFO feeding the instruction extractor.
// Accepts 0/1/2 halfwords and releases 0/1/2 halfwords per cycle; flush wins
// over push and pop. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module inst_align_buffer_halfword_fifo
  import inst_align_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_flush,
  input  logic [1:0]    i_push_cnt,
  input  halfword_t     i_push_hw0,
  input  halfword_t     i_push_hw1,
  input  logic [1:0]    i_pop_cnt,
  output halfword_t     o_head_hw0,
  output halfword_t     o_head_hw1,
  output logic [CW-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  halfword_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_head1;
  logic [PW-1:0]   w_tail1;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, k};
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  assign w_head1    = ptr_add(r_head, 2'd1);
  assign w_tail1    = ptr_add(r_tail, 2'd1);
  assign o_head_hw0 = r_mem[r_head];
  assign o_head_hw1 = r_mem[w_head1];
  assign o_count    = r_count;

  // Storage, pointers and occupancy; flush discards everything including a same-cycle push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push_cnt != 2'd0) r_mem[r_tail]  <= i_push_hw0;
      if (i_push_cnt == 2'd2) r_mem[w_tail1] <= i_push_hw1;
      r_tail  <= ptr_add(r_tail, i_push_cnt);
      r_head  <= ptr_add(r_head, i_pop_cnt);
      r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop_cnt);
    end
  end

endmodule

// File: rtl/inst_align_buffer.sv
// Instruction align buffer: word fetch from instruction memory, halfword queue,
// one aligned instruction per cycle with its PC, redirect handling.
// Define INST_ALIGN_COMPRESSED_EN to support 16-bit compressed instructions;
// without it every instruction is 32-bit and word aligned.
module inst_align_buffer
  import inst_align_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          HW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_compressed,
  input  logic        inst_ready,
  output logic        stall_compressed
);

  localparam int CW = $clog2(HW_DEPTH + 1);

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_inst_pc;
  logic [31:0]   r_imem_addr;
  logic          r_imem_req;
  logic          r_drop_low;

  halfword_t     w_h0;
  halfword_t     w_h1;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_need;
  logic          w_need_two;
  logic          w_inst_valid;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_can_issue;
  logic [1:0]    w_push_cnt;
  logic [1:0]    w_pop_cnt;
  halfword_t     w_push_hw0;
  logic          w_redir_drop;
  logic [31:0]   w_redir_pc;
  logic          w_unused;

`ifdef INST_ALIGN_COMPRESSED_EN
  localparam logic RESET_DROP = RESET_PC[1];
  assign w_need_two   = (w_h0[1:0] == OPC_UNCOMPRESSED);
  assign w_redir_drop = redirect_pc[1];
  assign w_redir_pc   = {redirect_pc[31:1], 1'b0};
`else
  localparam logic RESET_DROP = 1'b0;
  assign w_need_two   = 1'b1;
  assign w_redir_drop = 1'b0;
  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
`endif

  // Bit 0 of the redirect target is never used (bit 1 too when compressed support is off)
  assign w_unused = ^redirect_pc[1:0];

  assign w_need       = w_need_two ? CW'(2) : CW'(1);
  assign w_inst_valid = (w_count >= w_need) && !redirect_valid;
  assign w_pop        = w_inst_valid && inst_ready;
  assign w_pop_cnt    = !w_pop ? 2'd0 : (w_need_two ? 2'd2 : 2'd1);
  assign w_push_ok    = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign w_push_cnt   = !w_push_ok ? 2'd0 : (r_drop_low ? 2'd1 : 2'd2);
  assign w_push_hw0   = r_drop_low ? imem_rdata[31:16] : imem_rdata[15:0];
  // A new word can only be requested while it is guaranteed to fit
  assign w_can_issue  = (w_count <= CW'(HW_DEPTH - 2));

  inst_align_buffer_halfword_fifo #(
    .DEPTH (HW_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (redirect_valid),
    .i_push_cnt (w_push_cnt),
    .i_push_hw0 (w_push_hw0),
    .i_push_hw1 (imem_rdata[31:16]),
    .i_pop_cnt  (w_pop_cnt),
    .o_head_hw0 (w_h0),
    .o_head_hw1 (w_h1),
    .o_count    (w_count)
  );

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign inst_valid = w_inst_valid;
  assign inst_pc    = r_inst_pc;
  assign inst       = !w_inst_valid ? 32'h0 :
                      (w_need_two ? {w_h1, w_h0} : {16'h0, w_h0});

`ifdef INST_ALIGN_COMPRESSED_EN
  assign inst_compressed  = w_inst_valid && !w_need_two;
  assign stall_compressed = inst_ready && !w_inst_valid && (w_count == CW'(1)) && w_need_two;
`else
  assign inst_compressed  = 1'b0;
  assign stall_compressed = 1'b0;
`endif

  // Fetch FSM, fetch/issue address, drop-low flag and PC of the head instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_drop_low   <= RESET_DROP;
      r_inst_pc    <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= '0;
    end else if (redirect_valid) begin
      r_fetch_addr <= {redirect_pc[31:2], 2'b00};
      r_drop_low   <= w_redir_drop;
      r_inst_pc    <= w_redir_pc;
      // An outstanding read still has to complete; its data is thrown away
      case (r_state)
        WAIT, DISCARD: begin
          if (imem_rvalid) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
          end else begin
            r_state    <= DISCARD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end else begin
      if (w_pop) r_inst_pc <= r_inst_pc + (w_need_two ? 32'd4 : 32'd2);
      case (r_state)
        IDLE: begin
          if (w_can_issue) begin
            r_state     <= WAIT;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_fetch_addr;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_state      <= IDLE;
            r_imem_req   <= 1'b0;
            r_drop_low   <= 1'b0;
            r_fetch_addr <= r_fetch_addr + 32'd4;
          end
        end
        DISCARD: begin
          if (imem_rvalid) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_align_buffer.sv
// Self-checking bench for inst_align_buffer (RESET_PC = 0, HW_DEPTH = 4).
// Expectations follow INST_ALIGN_COMPRESSED_EN when the build defines it.
module tb_inst_align_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_compressed;
  logic        inst_ready;
  logic        stall_compressed;

  always #5 clk = ~clk;

  inst_align_buffer #(
    .RESET_PC (32'h0000_0000),
    .HW_DEPTH (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .inst_valid       (inst_valid),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_compressed  (inst_compressed),
    .inst_ready       (inst_ready),
    .stall_compressed (stall_compressed)
  );

  logic [31:0] mem [128];
  int          mem_lat;
  int          wait_cnt;
  logic [31:0] addr_log [$];
  int          stall_seen;
  int          checks;
  int          errors;

  typedef struct {
    int          ready_delay;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_c;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [6];
  int   nvec;

  // Memory model: answers a request mem_lat cycles after it first sees it, one-cycle pulse
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      imem_rvalid = 1'b0;
      wait_cnt    = 0;
    end else if (imem_rvalid) begin
      imem_rvalid = 1'b0;
    end else if (imem_req) begin
      if (wait_cnt >= mem_lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem[imem_addr[8:2]];
        addr_log.push_back(imem_addr);
        wait_cnt    = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clk) if (stall_compressed) stall_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    repeat (3) tick();
    addr_log.delete();
    reset_n = 1'b1;
  endtask

  // Waits (bounded) for a valid instruction, compares it, then lets it be accepted
  task automatic expect_inst(input string name, input logic [31:0] e_inst,
                             input logic [31:0] e_pc, input logic e_c);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(negedge clk);
      if (inst_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no inst_valid expected inst %08h", name, e_inst);
    end else begin
      chk({name, "_inst"}, inst, e_inst);
      chk({name, "_pc"}, inst_pc, e_pc);
      chk({name, "_c"}, {31'b0, inst_compressed}, {31'b0, e_c});
    end
    tick();
  endtask

  initial begin
    bit found;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    mem_lat        = 1;
    wait_cnt       = 0;
    stall_seen     = 0;
    checks         = 0;
    errors         = 0;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0013_4501;
    mem[1]  = 32'h4585_0005;
    mem[2]  = 32'h0010_0093;
    mem[3]  = 32'h0000_0013;
    mem[32] = 32'h0000_0073;
    mem[64] = 32'h4505_00FF;

`ifdef INST_ALIGN_COMPRESSED_EN
    nvec    = 6;
    vecs[0] = '{0,  32'h0000_4501, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{0,  32'h0005_0013, 32'h0000_0002, 1'b0, 1'b1};
    vecs[2] = '{0,  32'h0000_4585, 32'h0000_0006, 1'b1, 1'b0};
    vecs[3] = '{10, 32'h0010_0093, 32'h0000_0008, 1'b0, 1'b0};
    vecs[4] = '{0,  32'h0000_0013, 32'h0000_000C, 1'b0, 1'b0};
    vecs[5] = '{0,  32'h0000_0013, 32'h0000_0010, 1'b0, 1'b0};
`else
    nvec    = 5;
    vecs[0] = '{0,  32'h0013_4501, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{0,  32'h4585_0005, 32'h0000_0004, 1'b0, 1'b0};
    vecs[2] = '{10, 32'h0010_0093, 32'h0000_0008, 1'b0, 1'b0};
    vecs[3] = '{0,  32'h0000_0013, 32'h0000_000C, 1'b0, 1'b0};
    vecs[4] = '{0,  32'h0000_0013, 32'h0000_0010, 1'b0, 1'b0};
    vecs[5] = '{0,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
`endif

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_c", {31'b0, inst_compressed}, 32'h0);
    chk("rst_stall", {31'b0, stall_compressed}, 32'h0);
    tick();
    reset_n = 1'b1;

    // Sequential stream, with a long back-pressure window on one row
    for (int i = 0; i < nvec; i++) begin
      int s0;
      s0 = stall_seen;
      if (vecs[i].ready_delay > 0) begin
        inst_ready = 1'b0;
        repeat (vecs[i].ready_delay) tick();
        @(negedge clk);
        chk("hold_req_low", {31'b0, imem_req}, 32'h0);
        tick();
      end
      inst_ready = 1'b1;
      expect_inst($sformatf("row%0d", i), vecs[i].exp_inst, vecs[i].exp_pc, vecs[i].exp_c);
      chk($sformatf("row%0d_stall", i), {31'b0, (stall_seen != s0)}, {31'b0, vecs[i].exp_stall});
    end
    if (addr_log.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL addr_seq: got %0d requests expected at least 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) chk($sformatf("addr_seq%0d", i), addr_log[i], 32'(i * 4));
    end

    // Redirect while waiting on the read of address 8
    do_reset();
    mem_lat    = 4;
    inst_ready = 1'b1;
    found      = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    chk("wait8_found", {31'b0, found}, 32'h1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    chk("redir_masks_valid", {31'b0, inst_valid}, 32'h0);
    addr_log.delete();
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("discard_req_held", {31'b0, imem_req}, 32'h1);
    chk("discard_addr_held", imem_addr, 32'h8);
`ifdef INST_ALIGN_COMPRESSED_EN
    chk("redir_pc", inst_pc, 32'h0000_0102);
    expect_inst("redir_first", 32'h0000_4505, 32'h0000_0102, 1'b1);
`else
    chk("redir_pc", inst_pc, 32'h0000_0100);
    expect_inst("redir_first", 32'h4505_00FF, 32'h0000_0100, 1'b0);
`endif
    expect_inst("redir_second", 32'h0000_0013, 32'h0000_0104, 1'b0);
    if (addr_log.size() < 2) begin
      checks++;
      errors++;
      $display("FAIL redir_addrs: got %0d requests expected at least 2", addr_log.size());
    end else begin
      chk("redir_dropped_addr", addr_log[0], 32'h8);
      chk("redir_next_addr", addr_log[1], 32'h100);
    end

    // Redirect in the same cycle as read data
    do_reset();
    mem_lat = 1;
    found   = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (imem_rvalid) found = 1'b1;
    end
    chk("rv_found", {31'b0, found}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    #1;
    chk("rv_redir_valid", {31'b0, inst_valid}, 32'h0);
    addr_log.delete();
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rv_not_pushed", {31'b0, inst_valid}, 32'h0);
    chk("rv_req_low", {31'b0, imem_req}, 32'h0);
    chk("rv_pc", inst_pc, 32'h0000_0080);
    tick();
    inst_ready = 1'b1;
    expect_inst("rv_first", 32'h0000_0073, 32'h0000_0080, 1'b0);
    if (addr_log.size() < 1) begin
      checks++;
      errors++;
      $display("FAIL rv_addr: got no request expected 00000080");
    end else begin
      chk("rv_addr", addr_log[0], 32'h80);
    end

`ifndef INST_ALIGN_COMPRESSED_EN
    chk("no_stall_ever", 32'(stall_seen), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/inst_align_buffer.md
Name: inst_align_buffer

Overview:
- Fetch-side block directly upstream of the IF/ID register and the decode controller.
- Issues word-aligned instruction-memory reads and buffers the returned data as a halfword queue.
- Extracts one aligned 32-bit or 16-bit (compressed) instruction per cycle, with its PC.
- Handles instructions that straddle word boundaries, redirects (branch/jump, interrupt, mret), and the stall to the pipeline controller while an instruction is incomplete.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- HW_DEPTH, 4, halfword queue depth; must be an even number >= 4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  flush buffer and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC, halfword aligned (bit 0 ignored)
- imem_req  out  1  read request, held high until imem_rvalid
- imem_addr  out  32  word-aligned read address, bits [1:0] = 0
- imem_rvalid  in  1  read data valid, at least 1 cycle after request
- imem_rdata  in  32  read data; low halfword = lower address
- inst_valid  out  1  complete instruction available
- inst  out  32  instruction; compressed = {16'h0, halfword}
- inst_pc  out  32  PC of inst
- inst_compressed  out  1  inst is 16-bit
- inst_ready  in  1  consumer accepts (driven from IF/ID enable)
- stall_compressed  out  1  consumer ready but instruction incomplete

Behaviour:
- Reset (async, reset_n low):
  - queue empty; fetch_addr = RESET_PC & ~3; drop_low = RESET_PC[1]; inst_pc = RESET_PC.
  - State IDLE; imem_req = 0; inst_valid = 0; inst = 0; inst_compressed = 0; stall_compressed = 0.
- Queue: halfword FIFO with head pointer, tail pointer and count (0..HW_DEPTH); pointers wrap modulo HW_DEPTH.
- Fetch FSM:
  - IDLE -> WAIT when count <= HW_DEPTH-2. Action: imem_req = 1, imem_addr = fetch_addr.
  - WAIT:
    - on imem_rvalid, push both halfwords (only the high one if drop_low), clear drop_low, fetch_addr += 4, go to IDLE.
    - a new request may not be issued in the same cycle as the rvalid.
  - WAIT + redirect_valid without imem_rvalid -> DISCARD.
  - DISCARD -> IDLE on imem_rvalid; the data is dropped. imem_req is held high in DISCARD until the rvalid arrives.
  - WAIT + redirect_valid + imem_rvalid in the same cycle: data dropped, go to IDLE.
- Extraction, head halfword h0:
  - h0[1:0] != 2'b11 means compressed, need = 1; otherwise need = 2.
  - inst_valid = (count >= need) and not redirect_valid. Combinational from queue state.
- Handshake: when inst_valid & inst_ready, pop `need` halfwords and advance inst_pc by 2 or 4.
- stall_compressed = inst_ready & ~inst_valid & (count == 1) & (h0[1:0] == 2'b11).
- Redirect has priority over everything:
  - queue flushed; fetch_addr = redirect_pc & ~3; drop_low = redirect_pc[1]; inst_pc = redirect_pc & ~1.
  - a simultaneous pop is discarded.
- Push and pop in the same cycle are legal; count changes by pushed minus popped.
- Overflow is impossible by the issue rule.
- Wrap-around of fetch_addr from 32'hFFFF_FFFC to 0 is silent.

Optional Feature:
- Macro: INST_ALIGN_COMPRESSED_EN.
- Defined: behaviour as above.
- Undefined:
  - every instruction is treated as 32-bit, need = 2.
  - inst_compressed and stall_compressed are tied to 0.
  - drop_low is forced to 0 and redirect_pc[1:0] is ignored.
  - inst_pc advances only by 4.

Decomposition:
- Shared fetch package holds:
  - typedef halfword_t (logic [15:0])
  - enum fetch_state_t {IDLE, WAIT, DISCARD}
  - constant OPC_UNCOMPRESSED = 2'b11
- One sub-module: halfword_fifo (parameter DEPTH, push of 0/1/2 halfwords, pop of 0/1/2, flush, exposes the two head entries and the count).

Test Plan:
- Reset with RESET_PC = 0, memory returns 32'h0000_0013 at word 0 and 32'h0010_0093 at word 4, inst_ready = 1 -> imem_addr = 0 then 4; inst = 0x00000013 at pc 0, then 0x00100093 at pc 4; inst_compressed = 0.
- Word 0 = 32'h0013_4501 -> first inst = 0x00004501, compressed, pc 0; second head is 0x0013 with count 1 -> stall_compressed = 1 until word 4 arrives; then inst = {low(word4), 16'h0013} at pc 2.
- Redirect to 32'h0000_0102 while WAIT for address 8 -> DISCARD; the rvalid for address 8 is dropped; next imem_addr = 0x100; the low halfword is dropped; first inst_pc = 0x102.
- redirect_valid and imem_rvalid in the same cycle -> data not pushed; inst_valid = 0 that cycle; the next request targets the redirect word.
- inst_ready = 0 for 10 cycles -> at most HW_DEPTH halfwords buffered; imem_req = 0 once count > HW_DEPTH-2; no instruction lost or duplicated after inst_ready rises.
- INST_ALIGN_COMPRESSED_EN undefined, word 0 = 32'h0013_4501 -> inst = 0x00134501, pc 0; next pc 4; stall_compressed never asserts.
